// File: rtl/serial_subtraction.sv
// -----------------------------------------------------------------------------
// serial_subtraction
//   Bit-serial two's-complement subtractor, z = a - b, one bit per clock,
//   LSB first. A single full-adder cell computes a + ~b + 1: the carry starts
//   at 1 and each cycle adds a[i] and the inverted subtrahend bit b[i]. The
//   result bits are shifted into a partial-result register. When the last bit
//   has been processed, the result and flags are published in one step.
//
// Ports
//   clk       in   1  clock; all state updates on the rising edge
//   rst_n     in   1  synchronous active-low reset
//   start     in   1  operation request; sampled only in IDLE or DONE
//   a         in   N  minuend, captured when start is accepted
//   b         in   N  subtrahend, captured when start is accepted
//   busy      out  1  high while bits are being processed (RUN)
//   done      out  1  one-cycle pulse after z/flags have been updated
//   z         out  N  a - b modulo 2^N; held until the next completion
//   overFlow  out  1  signed overflow of the last result
//   borrow    out  1  unsigned borrow (a < b) of the last result
//   zero      out  1  last result equals zero
// -----------------------------------------------------------------------------
module serial_subtraction #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] z,
  output logic         overFlow,
  output logic         borrow,
  output logic         zero
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   res_q, res_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [N-1:0]   z_q, z_d;
  logic           ovf_q, ovf_d;
  logic           borrow_q, borrow_d;
  logic           zero_q, zero_d;

  // Full-adder cell operating on the current bit position.
  logic           a_bit;
  logic           nb_bit;
  logic           sum_bit;
  logic           carry_out;
  logic [N-1:0]   full_res;

  always_comb begin
    a_bit     = a_q[idx_q];
    nb_bit    = ~b_q[idx_q];
    sum_bit   = a_bit ^ nb_bit ^ carry_q;
    carry_out = (a_bit & nb_bit) | (a_bit & carry_q) | (nb_bit & carry_q);
    // New bit enters at the MSB; after N shifts bit 0 has reached position 0.
    full_res  = {sum_bit, res_q[N-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    z_d      = z_q;
    ovf_d    = ovf_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          idx_d   = '0;
          carry_d = 1'b1;  // the +1 of the two's-complement negation of b
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = carry_out;
        res_d   = full_res;
        if (idx_q == IW'(N - 1)) begin
          state_d  = DONE;
          z_d      = full_res;
          // Overflow only possible when operand signs differ and the result
          // sign departs from the minuend's sign.
          ovf_d    = (a_q[N-1] != b_q[N-1]) && (sum_bit != a_q[N-1]);
          borrow_d = ~carry_out;
          zero_d   = (full_res == '0);
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      z_q      <= '0;
      ovf_q    <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      z_q      <= z_d;
      ovf_q    <= ovf_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign z        = z_q;
  assign overFlow = ovf_q;
  assign borrow   = borrow_q;
  assign zero     = zero_q;

endmodule
